// File: rtl/sn76489_sound_generator.sv
// rtl/sn76489_sound_generator.sv - SN76489 tone/noise generators, volume table and PCM mixer
// Optional Game Gear stereo panning: define SN76489_GG_STEREO_EN.
module sn76489_sound_generator #(
  parameter int PRESCALE  = 16,
  parameter int VOL_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           freq1,
  input  logic [9:0]           freq2,
  input  logic [9:0]           freq3,
  input  logic [3:0]           att1,
  input  logic [3:0]           att2,
  input  logic [3:0]           att3,
  input  logic [3:0]           attNoise,
  input  logic [2:0]           noiseControl,
`ifdef SN76489_GG_STEREO_EN
  input  logic [7:0]           ggStereo,
  output logic [VOL_WIDTH+1:0] audioLeft,
  output logic [VOL_WIDTH+1:0] audioRight,
`endif
  output logic                 tone1,
  output logic                 tone2,
  output logic                 tone3,
  output logic                 noiseOut,
  output logic [VOL_WIDTH+1:0] audioMix
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int MW = VOL_WIDTH + 2;

  logic [PW-1:0]        prescaler;
  logic                 tick;
  logic [9:0]           freq [3];
  logic [9:0]           tone_cnt [3];
  logic [9:0]           cnt_next [3];
  logic [2:0]           tone;
  logic [2:0]           tone_next;
  logic [2:0]           nc_reg;
  logic [6:0]           noise_cnt;
  logic [6:0]           noise_cnt_next;
  logic [6:0]           noise_reload;
  logic                 noise_ff;
  logic                 noise_ff_next;
  logic                 noise_rise;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_shifted;
  logic [3:0]           levels;
  logic [VOL_WIDTH-1:0] vol [4];
  logic [MW-1:0]        mix_all;

  // Attenuation to linear volume, 2 dB per step, rescaled to VOL_WIDTH
  function automatic logic [VOL_WIDTH-1:0] vol_of(input logic [3:0] a);
    int base;
    int scaled;
    base = 0;
    case (a)
      4'd0:  base = 255;
      4'd1:  base = 203;
      4'd2:  base = 161;
      4'd3:  base = 128;
      4'd4:  base = 102;
      4'd5:  base = 81;
      4'd6:  base = 64;
      4'd7:  base = 51;
      4'd8:  base = 40;
      4'd9:  base = 32;
      4'd10: base = 25;
      4'd11: base = 20;
      4'd12: base = 16;
      4'd13: base = 13;
      4'd14: base = 10;
      default: base = 0;
    endcase
    scaled = (base * ((1 << VOL_WIDTH) - 1) + 127) / 255;
    return scaled[VOL_WIDTH-1:0];
  endfunction

  assign freq[0] = freq1;
  assign freq[1] = freq2;
  assign freq[2] = freq3;
  assign tick    = (prescaler == PW'(PRESCALE - 1));

  // Prescaler producing one generator tick every PRESCALE clocks
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prescaler <= '0;
    else if (tick) prescaler <= '0;
    else prescaler <= prescaler + 1'b1;
  end

  // Tone counters: reload on expiry and toggle; freq <= 1 pins the output high
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_next[i]  = tone_cnt[i];
      tone_next[i] = tone[i];
      if (tick) begin
        if (freq[i] <= 10'd1) begin
          cnt_next[i]  = '0;
          tone_next[i] = 1'b1;
        end else if (tone_cnt[i] <= 10'd1) begin
          cnt_next[i]  = freq[i];
          tone_next[i] = ~tone[i];
        end else begin
          cnt_next[i]  = tone_cnt[i] - 10'd1;
        end
      end
    end
  end

  // Tone state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tone <= '0;
      for (int i = 0; i < 3; i++) tone_cnt[i] <= '0;
    end else begin
      tone <= tone_next;
      for (int i = 0; i < 3; i++) tone_cnt[i] <= cnt_next[i];
    end
  end

  // Noise clock: own counter for rates 0..2, tone3 rising edge for rate 3
  always_comb begin
    noise_cnt_next = noise_cnt;
    noise_ff_next  = noise_ff;
    noise_rise     = 1'b0;
    case (nc_reg[1:0])
      2'd1:    noise_reload = 7'd32;
      2'd2:    noise_reload = 7'd64;
      default: noise_reload = 7'd16;
    endcase
    if (nc_reg[1:0] == 2'd3) begin
      noise_rise = ~tone[2] & tone_next[2];
    end else if (tick) begin
      if (noise_cnt <= 7'd1) begin
        noise_cnt_next = noise_reload;
        noise_ff_next  = ~noise_ff;
        noise_rise     = ~noise_ff;
      end else begin
        noise_cnt_next = noise_cnt - 7'd1;
      end
    end
  end

  assign lfsr_shifted = {(nc_reg[2] ? (lfsr[0] ^ lfsr[3]) : lfsr[0]), lfsr[15:1]};

  // Noise register bank; a changed control value restarts the generator and wins over a shift
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nc_reg    <= '0;
      noise_cnt <= '0;
      noise_ff  <= 1'b0;
      lfsr      <= 16'h8000;
    end else if (noiseControl != nc_reg) begin
      nc_reg    <= noiseControl;
      noise_cnt <= '0;
      noise_ff  <= 1'b0;
      lfsr      <= 16'h8000;
    end else begin
      noise_cnt <= noise_cnt_next;
      noise_ff  <= noise_ff_next;
      if (noise_rise) lfsr <= lfsr_shifted;
    end
  end

  assign tone1    = tone[0];
  assign tone2    = tone[1];
  assign tone3    = tone[2];
  assign noiseOut = lfsr[0];
  assign levels   = {lfsr[0], tone[2], tone[1], tone[0]};

  // Per-channel volume lookup and unmasked sum
  always_comb begin
    vol[0]  = vol_of(att1);
    vol[1]  = vol_of(att2);
    vol[2]  = vol_of(att3);
    vol[3]  = vol_of(attNoise);
    mix_all = '0;
    for (int i = 0; i < 4; i++) begin
      if (levels[i]) mix_all = mix_all + MW'(vol[i]);
    end
  end

  // Registered mono sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) audioMix <= '0;
    else audioMix <= mix_all;
  end

`ifdef SN76489_GG_STEREO_EN
  logic [7:0]    stereo_mask;
  logic [MW-1:0] mix_left;
  logic [MW-1:0] mix_right;

  // Left/right sums gated by the panning mask (bit order noise,t3,t2,t1)
  always_comb begin
    mix_left  = '0;
    mix_right = '0;
    for (int i = 0; i < 4; i++) begin
      if (levels[i] && stereo_mask[i+4]) mix_left  = mix_left  + MW'(vol[i]);
      if (levels[i] && stereo_mask[i])   mix_right = mix_right + MW'(vol[i]);
    end
  end

  // Panning mask and stereo sample registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stereo_mask <= 8'hFF;
      audioLeft   <= '0;
      audioRight  <= '0;
    end else begin
      stereo_mask <= ggStereo;
      audioLeft   <= mix_left;
      audioRight  <= mix_right;
    end
  end
`endif

endmodule
